// File: rtl/preg_release_router_pkg.sv
// Shared rename definitions: widths, bank selection and the reserved zero preg.
// Imported by the release router, its bank FIFO and the interface.
package preg_release_router_pkg;

  localparam int PREGW  = 7;
  localparam int BANKS  = 4;
  localparam int QDEPTH = 4;
  localparam int CNTW   = 3;
  localparam int PTRW   = $clog2(QDEPTH);
  localparam int BANKW  = $clog2(BANKS);

  typedef logic [PREGW-1:0] preg_t;
  typedef logic [CNTW-1:0]  cnt_t;

  localparam preg_t ZERO_PREG = '0;

  function automatic logic [BANKW-1:0] bank_of(input preg_t preg);
    return preg[BANKW-1:0];
  endfunction

endpackage

// File: rtl/preg_release_router_if.sv
// Commit-side lanes in, free-list write ports out.
// The master side is commit plus the free lists; the slave side is the router.
interface preg_release_router_if;
  import preg_release_router_pkg::*;

  logic [1:0]       CommitValid;
  logic [1:0]       CommitHasDst;
  preg_t            CommitOldPreg0;
  preg_t            CommitOldPreg1;
  logic             ReleaseReady;
  logic             FlushClean;
  logic [BANKS-1:0] FlWable;
  preg_t            FlDin0;
  preg_t            FlDin1;
  preg_t            FlDin2;
  preg_t            FlDin3;
  logic             Drained;

  modport master (
    output CommitValid, CommitHasDst, CommitOldPreg0, CommitOldPreg1, FlushClean,
    input  ReleaseReady, FlWable, FlDin0, FlDin1, FlDin2, FlDin3, Drained
  );

  modport slave (
    input  CommitValid, CommitHasDst, CommitOldPreg0, CommitOldPreg1, FlushClean,
    output ReleaseReady, FlWable, FlDin0, FlDin1, FlDin2, FlDin3, Drained
  );

endinterface

// File: rtl/preg_release_router_bank_fifo.sv
// Per-bank release FIFO: up to two writes (Din0 then Din1) and one read per cycle.
// Head is the oldest entry; Count is the live occupancy.
module release_bank_fifo
  import preg_release_router_pkg::*;
(
  input  logic       Clk,
  input  logic       Rest,
  input  logic       Clear,
  input  logic [1:0] Push,
  input  preg_t      Din0,
  input  preg_t      Din1,
  input  logic       Pop,
  output preg_t      Head,
  output cnt_t       Count
);

  preg_t           mem [QDEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr_lane1;
  logic [CNTW:0]   fill_after_push;

  // Lane1 lands behind lane0 when both push, otherwise at the tail itself.
  assign wr_ptr_lane1 = wr_ptr + PTRW'(Push[0]);

  // NOTE: storage has no reset; validity is tracked by the pointers and Count alone.
  always_ff @(posedge Clk) begin
    if (Push[0]) mem[wr_ptr]       <= Din0;
    if (Push[1]) mem[wr_ptr_lane1] <= Din1;
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else if (Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTRW'(Push[0]) + PTRW'(Push[1]);
      rd_ptr <= rd_ptr + PTRW'(Pop);
      Count  <= Count + CNTW'(Push[0]) + CNTW'(Push[1]) - CNTW'(Pop);
    end
  end

  assign Head = mem[rd_ptr];

  assign fill_after_push = {1'b0, Count} + (CNTW+1)'(Push[0]) + (CNTW+1)'(Push[1]);

  no_push_into_full: assert property (
    @(posedge Clk) disable iff (!Rest) !Clear |-> fill_after_push <= (CNTW+1)'(QDEPTH)
  );

endmodule

// File: rtl/preg_release_router.sv
// Steers up to two retiring old-destination pregs per cycle into per-bank FIFOs
// that drain one write per cycle into the four rename free lists.
module preg_release_router
  import preg_release_router_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rest,
  preg_release_router_if.slave bus
);

  cnt_t             count [BANKS];
  preg_t            head  [BANKS];
  logic [1:0]       push  [BANKS];
  logic [BANKS-1:0] pop;
  preg_t            lane_preg [2];
  logic [1:0]       lane_acc;
  logic             ready;
  logic             drained;

  assign lane_preg[0] = bus.CommitOldPreg0;
  assign lane_preg[1] = bus.CommitOldPreg1;

  // Ready leaves room for a two-lane push into any bank on the next edge.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ready   = 1'b1;
    drained = 1'b1;
    for (int b = 0; b < BANKS; b++) begin
      if (count[b] > cnt_t'(QDEPTH - 2)) ready = 1'b0;
      if (count[b] != '0) drained = 1'b0;
    end
  end

  always_comb begin
    lane_acc = '0;
    for (int i = 0; i < 2; i++) begin
      lane_acc[i] = bus.CommitValid[i] & bus.CommitHasDst[i] & ready
                  & ~bus.FlushClean & (lane_preg[i] != ZERO_PREG);
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign push[b] = {lane_acc[1] && (bank_of(lane_preg[1]) == BANKW'(b)),
                      lane_acc[0] && (bank_of(lane_preg[0]) == BANKW'(b))};
    assign pop[b]  = (count[b] != '0) && !bus.FlushClean;

    release_bank_fifo u_fifo (
      .Clk   (Clk),
      .Rest  (Rest),
      .Clear (bus.FlushClean),
      .Push  (push[b]),
      .Din0  (lane_preg[0]),
      .Din1  (lane_preg[1]),
      .Pop   (pop[b]),
      .Head  (head[b]),
      .Count (count[b])
    );
  end

  assign bus.ReleaseReady = ready;
  assign bus.Drained      = drained;
  assign bus.FlWable      = pop;

  // Idle write ports present zero rather than a stale head.
  assign bus.FlDin0 = pop[0] ? head[0] : ZERO_PREG;
  assign bus.FlDin1 = pop[1] ? head[1] : ZERO_PREG;
  assign bus.FlDin2 = pop[2] ? head[2] : ZERO_PREG;
  assign bus.FlDin3 = pop[3] ? head[3] : ZERO_PREG;

endmodule

// File: tb/tb_preg_release_router.sv
// Scoreboard bench: accepted pregs are queued per bank and compared in order
// against the free-list write ports every cycle.
module tb_preg_release_router;
  import preg_release_router_pkg::*;

  logic Clk;
  logic Rest;
  preg_release_router_if bus ();

  preg_release_router dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks;
  int errors;
  preg_t sb [BANKS][$];

  function automatic preg_t din_of(input int b);
    case (b)
      0:       return bus.FlDin0;
      1:       return bus.FlDin1;
      2:       return bus.FlDin2;
      default: return bus.FlDin3;
    endcase
  endfunction

  task automatic set_lanes(input logic [1:0] v, input logic [1:0] h,
                           input preg_t p0, input preg_t p1, input logic flush);
    bus.CommitValid    = v;
    bus.CommitHasDst   = h;
    bus.CommitOldPreg0 = p0;
    bus.CommitOldPreg1 = p1;
    bus.FlushClean     = flush;
  endtask

  // One clock: compare outputs at the falling edge against the model, advance the
  // model to the rising edge, and return 1 ps... 1 time unit after it.
  task automatic cycle(output bit acc);
    logic             exp_ready;
    logic             exp_drained;
    logic [BANKS-1:0] exp_wable;
    preg_t            exp_din;
    preg_t            lane [2];
    @(negedge Clk);
    exp_ready   = 1'b1;
    exp_drained = 1'b1;
    for (int b = 0; b < BANKS; b++) begin
      if (sb[b].size() > QDEPTH - 2) exp_ready = 1'b0;
      if (sb[b].size() != 0) exp_drained = 1'b0;
      exp_wable[b] = (sb[b].size() != 0) && !bus.FlushClean;
    end
    checks++;
    if (bus.ReleaseReady !== exp_ready) begin
      errors++;
      $display("FAIL ready @%0t: got %b expected %b", $time, bus.ReleaseReady, exp_ready);
    end
    checks++;
    if (bus.Drained !== exp_drained) begin
      errors++;
      $display("FAIL drained @%0t: got %b expected %b", $time, bus.Drained, exp_drained);
    end
    checks++;
    if (bus.FlWable !== exp_wable) begin
      errors++;
      $display("FAIL wable @%0t: got %b expected %b", $time, bus.FlWable, exp_wable);
    end
    for (int b = 0; b < BANKS; b++) begin
      exp_din = exp_wable[b] ? sb[b][0] : ZERO_PREG;
      checks++;
      if (din_of(b) !== exp_din) begin
        errors++;
        $display("FAIL din%0d @%0t: got %0d expected %0d", b, $time, din_of(b), exp_din);
      end
      if (exp_wable[b]) void'(sb[b].pop_front());
    end
    acc = exp_ready && !bus.FlushClean;
    lane[0] = bus.CommitOldPreg0;
    lane[1] = bus.CommitOldPreg1;
    if (bus.FlushClean) begin
      for (int b = 0; b < BANKS; b++) sb[b].delete();
    end else if (exp_ready) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.CommitValid[i] && bus.CommitHasDst[i] && lane[i] != ZERO_PREG)
          sb[bank_of(lane[i])].push_back(lane[i]);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    set_lanes(2'b00, 2'b00, '0, '0, 1'b0);
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  // Present lanes and hold them until the model says they were taken.
  task automatic send(input logic [1:0] v, input logic [1:0] h, input preg_t p0, input preg_t p1);
    bit acc;
    int n;
    n = 0;
    set_lanes(v, h, p0, p1, 1'b0);
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 20);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no acceptance after %0d cycles, required acceptance", n);
    end
    set_lanes(2'b00, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    Rest = 1'b0;
    set_lanes(2'b11, 2'b11, 7'd9, 7'd13, 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (bus.FlWable !== 4'b0000 || bus.ReleaseReady !== 1'b1 || bus.Drained !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got wable=%b ready=%b drained=%b required 0000/1/1",
               bus.FlWable, bus.ReleaseReady, bus.Drained);
    end
    checks++;
    if ({bus.FlDin0, bus.FlDin1, bus.FlDin2, bus.FlDin3} !== '0) begin
      errors++;
      $display("FAIL reset_din: got %0d/%0d/%0d/%0d required all 0",
               bus.FlDin0, bus.FlDin1, bus.FlDin2, bus.FlDin3);
    end
    set_lanes(2'b00, 2'b00, '0, '0, 1'b0);
    Rest = 1'b1;
    idle(2);
  endtask

  task automatic test_two_banks();
    bit acc;
    send(2'b11, 2'b11, 7'd35, 7'd12);
    checks++;
    if (bus.FlWable !== 4'b1001 || bus.FlDin3 !== 7'd35 || bus.FlDin0 !== 7'd12) begin
      errors++;
      $display("FAIL two_banks: got wable=%b din3=%0d din0=%0d required 1001/35/12",
               bus.FlWable, bus.FlDin3, bus.FlDin0);
    end
    cycle(acc);
    checks++;
    if (bus.Drained !== 1'b1) begin
      errors++;
      $display("FAIL two_banks_drained: got %b required 1", bus.Drained);
    end
  endtask

  task automatic test_same_bank();
    bit acc;
    send(2'b11, 2'b11, 7'd39, 7'd43);
    checks++;
    if (bus.FlWable !== 4'b1000 || bus.FlDin3 !== 7'd39) begin
      errors++;
      $display("FAIL same_bank_first: got wable=%b din3=%0d required 1000/39", bus.FlWable, bus.FlDin3);
    end
    cycle(acc);
    checks++;
    if (bus.FlWable !== 4'b1000 || bus.FlDin3 !== 7'd43) begin
      errors++;
      $display("FAIL same_bank_second: got wable=%b din3=%0d required 1000/43", bus.FlWable, bus.FlDin3);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    send(2'b11, 2'b11, 7'd7, 7'd11);
    send(2'b11, 2'b11, 7'd15, 7'd19);
    checks++;
    if (bus.ReleaseReady !== 1'b0) begin
      errors++;
      $display("FAIL backpressure: got ready=%b with three queued, required 0", bus.ReleaseReady);
    end
    send(2'b11, 2'b11, 7'd23, 7'd27);
    idle(6);
  endtask

  task automatic test_zero_preg();
    send(2'b11, 2'b11, 7'd0, 7'd5);
    checks++;
    if (bus.FlWable !== 4'b0010 || bus.FlDin1 !== 7'd5) begin
      errors++;
      $display("FAIL zero_preg: got wable=%b din1=%0d required 0010/5", bus.FlWable, bus.FlDin1);
    end
    idle(2);
  endtask

  task automatic test_flush();
    bit acc;
    send(2'b11, 2'b11, 7'd2, 7'd6);
    send(2'b11, 2'b11, 7'd10, 7'd14);
    set_lanes(2'b11, 2'b11, 7'd6, 7'd10, 1'b1);
    #1;
    checks++;
    if (bus.FlWable !== 4'b0000) begin
      errors++;
      $display("FAIL flush_wable: got %b required 0000", bus.FlWable);
    end
    cycle(acc);
    set_lanes(2'b00, 2'b00, '0, '0, 1'b0);
    #1;
    checks++;
    if (bus.Drained !== 1'b1 || bus.ReleaseReady !== 1'b1 || bus.FlWable !== 4'b0000) begin
      errors++;
      $display("FAIL flush_after: got drained=%b ready=%b wable=%b required 1/1/0000",
               bus.Drained, bus.ReleaseReady, bus.FlWable);
    end
    idle(4);
  endtask

  task automatic test_async_reset();
    send(2'b11, 2'b11, 7'd9, 7'd13);
    Rest = 1'b0;
    #1;
    checks++;
    if (bus.FlWable !== 4'b0000 || bus.Drained !== 1'b1 || bus.FlDin1 !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got wable=%b drained=%b din1=%0d required 0000/1/0",
               bus.FlWable, bus.Drained, bus.FlDin1);
    end
    for (int b = 0; b < BANKS; b++) sb[b].delete();
    @(negedge Clk);
    Rest = 1'b1;
    @(posedge Clk);
    #1;
    idle(2);
  endtask

  task automatic test_random();
    bit         acc;
    logic [1:0] v;
    logic [1:0] h;
    preg_t      p0;
    preg_t      p1;
    acc = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (acc || v == 2'b00) begin
        v  = 2'($urandom_range(3, 0));
        h  = 2'($urandom_range(3, 0));
        p0 = PREGW'($urandom_range(15, 0));
        p1 = PREGW'($urandom_range(15, 0));
      end
      set_lanes(v, h, p0, p1, ($urandom_range(24, 0) == 0));
      cycle(acc);
    end
    idle(8);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_two_banks();
    test_same_bank();
    test_back_to_back();
    test_zero_preg();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
